// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program counter sequencing with imem handshake and redirect/flush control
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] jump_target_i,
    input  logic             br_taken_i,
    input  logic [WIDTH-1:0] br_target_i,
    input  logic             trap_i,
    input  logic [WIDTH-1:0] trap_pc_i,
    input  logic             mret_i,
    output logic             imem_req_o,
    input  logic             imem_ready_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic [WIDTH-1:0] mepc_o
);
    typedef enum logic [1:0] {BOOT, FETCH, WAIT} state_t;
    state_t           state;
    logic             pend_valid;
    logic [1:0]       pend_prio;
    logic [WIDTH-1:0] pend_target;
    logic             redir;
    logic             rdy;
    logic             take_new;
    logic [1:0]       prio;
    logic [WIDTH-1:0] target;
    assign pc_plus4_o = pc_o + WIDTH'(4);
    // winning redirect, its rank (3=trap..0=jump) and whether it beats a held redirect
    always_comb begin
        redir    = trap_i || mret_i || br_taken_i || jump_i;
        prio     = trap_i ? 2'd3 : mret_i ? 2'd2 : br_taken_i ? 2'd1 : 2'd0;
        target   = trap_i ? TRAP_VECTOR : mret_i ? mepc_o : br_taken_i ? br_target_i : jump_target_i;
        rdy      = imem_ready_i && state != BOOT;
        take_new = redir && (!pend_valid || prio >= pend_prio);
        flush_if_id_o = reset_n && (redir || (rdy && pend_valid));
        flush_id_ex_o = reset_n && (trap_i || mret_i || br_taken_i);
    end
    // fetch FSM: PC update, pending redirect capture and trap PC save
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BOOT;
            imem_req_o  <= 1'b0;
            pc_o        <= RESET_VECTOR;
            mepc_o      <= '0;
            pend_valid  <= 1'b0;
            pend_prio   <= '0;
            pend_target <= '0;
        end else begin
            if (trap_i) mepc_o <= trap_pc_i;
            if (state == BOOT) begin
                state      <= FETCH;
                imem_req_o <= 1'b1;
                if (redir) pc_o <= target;
            end else if (imem_ready_i) begin
                state      <= FETCH;
                pend_valid <= 1'b0;
                pc_o       <= take_new ? target : pend_valid ? pend_target : stall_i ? pc_o : pc_plus4_o;
            end else begin
                state <= WAIT;
                if (take_new) begin
                    pend_valid  <= 1'b1;
                    pend_prio   <= prio;
                    pend_target <= target;
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer against a behavioural PC model
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall_i = 0, jump_i = 0, br_taken_i = 0, trap_i = 0, mret_i = 0, imem_ready_i = 0;
    logic [31:0] jump_target_i = 0, br_target_i = 0, trap_pc_i = 0;
    logic        imem_req_o, flush_if_id_o, flush_id_ex_o;
    logic [31:0] pc_o, pc_plus4_o, mepc_o;

    pc_sequencer dut (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i),
        .jump_i(jump_i), .jump_target_i(jump_target_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .trap_i(trap_i), .trap_pc_i(trap_pc_i), .mret_i(mret_i),
        .imem_req_o(imem_req_o), .imem_ready_i(imem_ready_i),
        .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
        .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o), .mepc_o(mepc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req, fif, fie;
        logic [31:0] pc, mepc;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // model state: booting flag, PC, saved trap PC, one held redirect
    bit          m_boot;
    logic [31:0] m_pc, m_mepc, m_pt;
    bit          m_pv;
    int          m_pp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_pc = 0; m_mepc = 0; m_pv = 0; m_pt = 0; m_pp = -1;
    endtask

    // one cycle: drive inputs, predict outputs for this cycle, then apply the edge to the model
    task automatic step(input bit st, input bit rdy, input bit j, input logic [31:0] jt,
                        input bit b, input logic [31:0] bt, input bit t, input logic [31:0] tp,
                        input bit m);
        exp_t        e;
        int          rank;
        logic [31:0] tgt;
        stall_i = st; imem_ready_i = rdy; jump_i = j; jump_target_i = jt;
        br_taken_i = b; br_target_i = bt; trap_i = t; trap_pc_i = tp; mret_i = m;
        rank = t ? 3 : m ? 2 : b ? 1 : j ? 0 : -1;
        tgt  = t ? 32'h100 : m ? m_mepc : b ? bt : jt;
        e.req  = !m_boot;
        e.fif  = (rank >= 0) || (!m_boot && rdy && m_pv);
        e.fie  = t || m || b;
        e.pc   = m_pc;
        e.mepc = m_mepc;
        q.push_back(e);
        @(posedge clk);
        if (t) m_mepc = tp;
        if (m_boot) begin
            m_boot = 0;
            if (rank >= 0) m_pc = tgt;
        end else if (rdy) begin
            if (rank >= 0 && rank >= m_pp) m_pc = tgt;
            else if (m_pv) m_pc = m_pt;
            else if (!st) m_pc = m_pc + 4;
            m_pv = 0; m_pp = -1;
        end else if (rank >= 0 && rank >= m_pp) begin
            m_pv = 1; m_pt = tgt; m_pp = rank;
        end
        #1;
    endtask

    task automatic go(input bit rdy);
        step(0, rdy, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // monitor: compare every cycle that has a prediction queued
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imem_req", {31'd0, imem_req_o}, {31'd0, e.req});
                chk("flush_if_id", {31'd0, flush_if_id_o}, {31'd0, e.fif});
                chk("flush_id_ex", {31'd0, flush_id_ex_o}, {31'd0, e.fie});
                chk("pc", pc_o, e.pc);
                chk("pc_plus4", pc_plus4_o, e.pc + 32'd4);
                chk("mepc", mepc_o, e.mepc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        model_reset();
        #12;
        chk("reset_pc", pc_o, 32'h0);
        chk("reset_req", {31'd0, imem_req_o}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1;
        // boot then sequential 0,4,8; stall twice at 8; then 12
        go(1); go(1); go(1);
        chk("at_8", m_pc, 32'h8);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        go(1);
        // branch beats jump in the same cycle
        step(0, 1, 1, 32'h80, 1, 32'h40, 0, 0, 0);
        go(1);
        // jump alone, then advance to 0x24
        step(0, 1, 1, 32'h20, 0, 0, 0, 0, 0);
        go(1);
        // trap from 0x24, a few fetches, then return
        step(0, 1, 0, 0, 0, 0, 1, 32'h24, 0);
        go(1); go(1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1);
        go(1);
        // branch arriving while fetch of 0x10 is stalled on memory
        step(0, 1, 1, 32'h10, 0, 0, 0, 0, 0);
        go(0);
        step(0, 0, 0, 0, 1, 32'h200, 0, 0, 0);
        go(0);
        go(1); go(1);
        // wrap at the top of the address space
        step(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        go(1); go(1);
        // async reset during a wait with a held redirect
        go(0);
        step(0, 0, 0, 0, 1, 32'h300, 0, 0, 0);
        imem_ready_i = 0; br_taken_i = 1; br_target_i = 32'h400;
        reset_n = 0;
        #1;
        chk("async_reset_pc", pc_o, 32'h0);
        chk("async_reset_req", {31'd0, imem_req_o}, 32'h0);
        chk("async_reset_fif", {31'd0, flush_if_id_o}, 32'h0);
        chk("async_reset_fie", {31'd0, flush_id_ex_o}, 32'h0);
        br_taken_i = 0;
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        reset_n = 1;
        go(1); go(1); go(1); go(1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 10, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 99) < 8, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 99) < 4, $urandom,
                 $urandom_range(0, 99) < 5);
        end
        go(1);
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns and sequences the fetch program counter for the 5-stage RISC-V pipeline.
- Each cycle it selects the next PC from: reset vector, sequential PC+4, ID-stage jump, EX-stage branch, trap vector or MRET return.
- Runs the instruction-memory request/ready handshake, holds a redirect that arrives while a fetch is outstanding, and drives the IF/ID and ID/EX flush strobes.

Parameters:
- WIDTH, 32, PC and address width.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- stall_i  in  1  load-use hazard; hold PC
- jump_i  in  1  JAL/JALR resolved in ID
- jump_target_i  in  WIDTH  jump destination
- br_taken_i  in  1  branch resolved taken in EX
- br_target_i  in  WIDTH  branch destination
- trap_i  in  1  exception or ecall from EX
- trap_pc_i  in  WIDTH  PC of the trapping instruction
- mret_i  in  1  MRET in EX
- imem_req_o  out  1  fetch request
- imem_ready_i  in  1  fetch completes this cycle
- pc_o  out  WIDTH  current fetch address
- pc_plus4_o  out  WIDTH  pc_o+4, combinational
- flush_if_id_o  out  1  kill the IF/ID entry
- flush_id_ex_o  out  1  kill the ID/EX entry
- mepc_o  out  WIDTH  saved trap PC

Behaviour:
- Reset (asynchronous):
  - pc_o=RESET_VECTOR, mepc_o=0, pend_valid=0, pend_target=0, state=BOOT.
  - imem_req_o=0 and both flushes=0 while reset is asserted.
- State BOOT:
  - imem_req_o=0 for one cycle.
  - Next state FETCH. pc_o is unchanged.
- State FETCH:
  - imem_req_o=1. pc_o is stable until imem_ready_i=1.
  - imem_ready_i=0: next state WAIT.
- State WAIT:
  - imem_req_o=1. pc_o is held stable.
  - Leaves WAIT on imem_ready_i=1.
- Redirect priority, highest first: trap_i, mret_i, br_taken_i, jump_i.
  - Targets: TRAP_VECTOR, mepc_o, br_target_i, jump_target_i.
  - Only the winner acts. Lower requests in the same cycle are ignored; the pipeline kills them via flush.
- On trap_i: mepc_o <= trap_pc_i in the same edge, regardless of state.
- Redirect handling when imem_ready_i=1 or state=BOOT:
  - pc_o <= target at the next edge. stall_i is ignored.
- Redirect handling in FETCH or WAIT with imem_ready_i=0:
  - Latch pend_valid=1 and pend_target=target. pc_o is unchanged.
  - A later, higher-or-equal-priority redirect overwrites the pending target.
- When imem_ready_i=1 with pend_valid=1:
  - pc_o <= pend_target and pend_valid <= 0.
  - flush_if_id_o=1 that cycle, so the stale instruction is dropped.
- Flush strobes, asserted combinationally in the cycle the redirect is presented:
  - trap, mret and branch: flush_if_id_o=1 and flush_id_ex_o=1.
  - jump: flush_if_id_o=1 only.
- Sequential advance (no redirect, no pending redirect, imem_ready_i=1, stall_i=0): pc_o <= pc_o+4.
- stall_i=1 with imem_ready_i=1 and no redirect: pc_o holds, and the request re-issues next cycle in FETCH.
- Arithmetic: PC+4 wraps modulo 2^WIDTH (32'hFFFF_FFFC -> 0). No alignment checking is done.
- Latency: redirect-to-new-fetch-address is 1 cycle with memory ready, otherwise 1 cycle after imem_ready_i.
- Reset asserted mid-WAIT drops the pending redirect and returns to BOOT.

Test Plan:
- Reset release, imem_ready_i=1 constant:
  - pc_o=0 through BOOT (imem_req_o=0), then 0,4,8,12 on consecutive cycles.
- Stall: stall_i=1 for 2 cycles at pc_o=8 -> pc_o stays 8 for 2 cycles, then 12.
- Simultaneous requests:
  - br_taken_i with target 0x40 and jump_i with target 0x80 in one cycle -> pc_o=0x40, flush_if_id_o=1 and flush_id_ex_o=1.
  - jump alone -> flush_id_ex_o=0.
- Trap then return:
  - trap_i with trap_pc_i=0x24 -> pc_o=0x100, mepc_o=0x24.
  - Later mret_i -> pc_o=0x24.
- Redirect during a memory wait:
  - imem_ready_i=0 for 3 cycles at pc_o=0x10; br_taken_i with target 0x200 pulsed in wait cycle 1.
  - pc_o stays 0x10 until ready; on the ready cycle flush_if_id_o=1, and the next pc_o=0x200.
- Wrap and async reset:
  - pc_o=0xFFFF_FFFC advances to 0.
  - reset_n low mid-WAIT with a pending redirect -> pc_o=0 immediately, and the pending redirect is not applied after release.
